// File: rtl/shift_unit_iter_pkg.sv
// Shared definitions for the iterative shift unit: op encodings and FSM states.
package shift_unit_pkg;

    // Shift mode encodings carried on Op and held in the sampled op register
    localparam logic [1:0] SHIFT_SLL = 2'b00;
    localparam logic [1:0] SHIFT_SRL = 2'b01;
    localparam logic [1:0] SHIFT_SRA = 2'b10;
    localparam logic [1:0] SHIFT_ROR = 2'b11;

    // Control FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_unit_iter_step.sv
// Combinational single-step shifter: moves acc by k (0..STEP) positions in the
// selected mode. Repeated application composes exactly into one larger shift.
module shift_step
    import shift_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 1,
    localparam int unsigned KW   = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] acc_i,
    input  logic [1:0]       op_i,
    input  logic             sign_i,
    input  logic [KW-1:0]    k_i,
    output logic [WIDTH-1:0] result_o
);

    logic [WIDTH-1:0] fill_mask;
    logic [WIDTH-1:0] srl_w;

    // Shift acc by k in the mode held in op; SRA fills with the sampled sign,
    // ROR wraps LSB-side bits around to the MSB side.
    always_comb begin
        srl_w     = acc_i >> k_i;
        // Ones in every position still occupied by original bits after >> k
        fill_mask = {WIDTH{1'b1}} >> k_i;
        result_o  = acc_i;
        case (op_i)
            SHIFT_SLL: result_o = acc_i << k_i;
            SHIFT_SRL: result_o = srl_w;
            SHIFT_SRA: result_o = srl_w | (~fill_mask & {WIDTH{sign_i}});
            // A shift by WIDTH yields zero, so k=0 leaves acc unchanged
            SHIFT_ROR: result_o = srl_w | (acc_i << (WIDTH - 32'(k_i)));
            default:   result_o = acc_i;
        endcase
    end

endmodule

// File: rtl/shift_unit_iter.sv
// Iterative variable-amount shifter (SLL/SRL/SRA/ROR). Accepts one operand per
// Start/Done handshake and advances up to STEP bit positions per clock.
module shift_unit_iter
    import shift_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     Start,
    input  logic [1:0]               Op,
    input  logic [$clog2(WIDTH)-1:0] Shamt,
    input  logic [WIDTH-1:0]         Data_In,
    output logic                     Busy,
    output logic                     Done,
    output logic [WIDTH-1:0]         Data_Out
);

    localparam int unsigned SW = $clog2(WIDTH);
    localparam int unsigned KW = $clog2(STEP + 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q,   acc_d;
    logic [SW-1:0]    cnt_q,   cnt_d;
    logic [1:0]       op_q,    op_d;
    logic             sign_q,  sign_d;
    logic [WIDTH-1:0] dout_q,  dout_d;

    logic [KW-1:0]    k;
    logic [WIDTH-1:0] step_res;

    // Per-cycle step size: the full STEP, or whatever remains if smaller
    always_comb begin
        if (32'(cnt_q) >= STEP) begin
            k = KW'(STEP);
        end else begin
            k = KW'(cnt_q);
        end
    end

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .acc_i    (acc_q),
        .op_i     (op_q),
        .sign_i   (sign_q),
        .k_i      (k),
        .result_o (step_res)
    );

    // Next-state logic: accept in IDLE/DONE, iterate in SHIFT, publish on exit
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        sign_d  = sign_q;
        dout_d  = dout_q;
        case (state_q)
            IDLE, DONE: begin
                if (Start) begin
                    state_d = SHIFT;
                    acc_d   = Data_In;
                    cnt_d   = Shamt;
                    op_d    = Op;
                    sign_d  = Data_In[WIDTH-1];
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    acc_d = step_res;
                    // k never exceeds cnt, so narrowing to SW bits is lossless
                    cnt_d = cnt_q - SW'(k);
                end else begin
                    state_d = DONE;
                    dout_d  = acc_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            sign_q  <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            sign_q  <= sign_d;
            dout_q  <= dout_d;
        end
    end

    assign Busy     = (state_q == SHIFT);
    assign Done     = (state_q == DONE);
    assign Data_Out = dout_q;

endmodule

// File: tb/tb_shift_unit_iter.sv
// Directed self-checking bench for shift_unit_iter: one STEP=1 and one STEP=4
// instance, each with its own Start, sharing the operand inputs.
module tb_shift_unit_iter;

    logic        clk;
    logic        rst;
    logic        start1, start4;
    logic [1:0]  op;
    logic [4:0]  shamt;
    logic [31:0] din;
    logic        busy1, done1, busy4, done4;
    logic [31:0] dout1, dout4;

    int checks = 0;
    int errors = 0;
    int cyc;

    shift_unit_iter #(.WIDTH(32), .STEP(1)) u_dut1 (
        .clk(clk), .rst(rst), .Start(start1), .Op(op), .Shamt(shamt),
        .Data_In(din), .Busy(busy1), .Done(done1), .Data_Out(dout1)
    );

    shift_unit_iter #(.WIDTH(32), .STEP(4)) u_dut4 (
        .clk(clk), .rst(rst), .Start(start4), .Op(op), .Shamt(shamt),
        .Data_In(din), .Busy(busy4), .Done(done4), .Data_Out(dout4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Drive a request (called at posedge+1), pass edge E0, drop Start.
    task automatic launch(input bit sel, input logic [1:0] o, input logic [4:0] s,
                          input logic [31:0] d);
        op = o; shamt = s; din = d;
        if (sel) start4 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; start4 = 1'b0;
    endtask

    // Count cycles after E0 until Done is seen, bounded.
    task automatic wait_done(input bit sel, output int c);
        c = 0;
        while (((sel ? done4 : done1) !== 1'b1) && c < 64) begin
            @(posedge clk); #1;
            c++;
        end
    endtask

    initial begin
        rst = 1'b1; start1 = 1'b0; start4 = 1'b0;
        op = 2'b00; shamt = '0; din = '0;
        #1;
        check("rst_busy1", {31'b0, busy1}, 32'd0);
        check("rst_done1", {31'b0, done1}, 32'd0);
        check("rst_dout1", dout1, 32'd0);
        check("rst_dout4", dout4, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // SLL 1 by 31, STEP=1: 32 cycles
        launch(1'b0, 2'b00, 5'd31, 32'h0000_0001);
        check("sll31_busy", {31'b0, busy1}, 32'd1);
        wait_done(1'b0, cyc);
        check("sll31_lat", cyc, 32'd32);
        check("sll31_res", dout1, 32'h8000_0000);
        @(posedge clk); #1;
        check("sll31_pulse", {31'b0, done1}, 32'd0);
        check("sll31_hold", dout1, 32'h8000_0000);

        // SRA / SRL of 0xF0000000 by 4
        launch(1'b0, 2'b10, 5'd4, 32'hF000_0000);
        wait_done(1'b0, cyc);
        check("sra4_lat", cyc, 32'd5);
        check("sra4_res", dout1, 32'hFF00_0000);
        @(posedge clk); #1;
        launch(1'b0, 2'b01, 5'd4, 32'hF000_0000);
        wait_done(1'b0, cyc);
        check("srl4_lat", cyc, 32'd5);
        check("srl4_res", dout1, 32'h0F00_0000);
        @(posedge clk); #1;

        // ROR by 6 with STEP=4: steps of 4 then 2
        launch(1'b1, 2'b11, 5'd6, 32'h1234_5678);
        wait_done(1'b1, cyc);
        check("ror6_lat", cyc, 32'd3);
        check("ror6_res", dout4, 32'hE048_D159);
        @(posedge clk); #1;

        // SLL by 5 with STEP=4 (partial last step)
        launch(1'b1, 2'b00, 5'd5, 32'h0000_0003);
        wait_done(1'b1, cyc);
        check("sll5_s4_lat", cyc, 32'd3);
        check("sll5_s4_res", dout4, 32'h0000_0060);
        @(posedge clk); #1;

        // Shamt = 0
        launch(1'b0, 2'b10, 5'd0, 32'hDEAD_BEEF);
        wait_done(1'b0, cyc);
        check("sh0_lat", cyc, 32'd1);
        check("sh0_res", dout1, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        launch(1'b1, 2'b11, 5'd0, 32'hDEAD_BEEF);
        wait_done(1'b1, cyc);
        check("sh0_s4_lat", cyc, 32'd1);
        check("sh0_s4_res", dout4, 32'hDEAD_BEEF);
        @(posedge clk); #1;

        // Inputs change after accept: sampled copies only
        launch(1'b0, 2'b00, 5'd3, 32'h0000_0003);
        din = 32'hFFFF_FFFF; op = 2'b11; shamt = 5'd31;
        wait_done(1'b0, cyc);
        check("sampled_lat", cyc, 32'd4);
        check("sampled_res", dout1, 32'h0000_0018);
        @(posedge clk); #1;

        // Start held high: ignored while busy, re-accepted in DONE
        op = 2'b00; shamt = 5'd2; din = 32'h0000_0001; start1 = 1'b1;
        @(posedge clk); #1;
        din = 32'h0000_0003;
        check("b2b_busy", {31'b0, busy1}, 32'd1);
        wait_done(1'b0, cyc);
        check("b2b1_lat", cyc, 32'd3);
        check("b2b1_res", dout1, 32'h0000_0004);
        @(posedge clk); #1;
        start1 = 1'b0;
        check("b2b_reaccept_busy", {31'b0, busy1}, 32'd1);
        check("b2b_reaccept_done", {31'b0, done1}, 32'd0);
        check("b2b_hold", dout1, 32'h0000_0004);
        wait_done(1'b0, cyc);
        check("b2b2_lat", cyc, 32'd3);
        check("b2b2_res", dout1, 32'h0000_000C);
        @(posedge clk); #1;
        check("b2b_idle_done", {31'b0, done1}, 32'd0);
        check("b2b_idle_busy", {31'b0, busy1}, 32'd0);

        // Reset in mid-SHIFT: outputs drop without a clock edge
        launch(1'b0, 2'b00, 5'd20, 32'h0000_0001);
        repeat (5) @(posedge clk);
        #1;
        check("pre_rst_busy", {31'b0, busy1}, 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst_busy", {31'b0, busy1}, 32'd0);
        check("async_rst_done", {31'b0, done1}, 32'd0);
        check("async_rst_dout", dout1, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        launch(1'b0, 2'b00, 5'd1, 32'h0000_0001);
        wait_done(1'b0, cyc);
        check("post_rst_lat", cyc, 32'd2);
        check("post_rst_res", dout1, 32'h0000_0002);
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_unit_iter.md
# shift_unit_iter

Iterative, parametrised shift unit for the processor datapath, generalising the fixed left-shift-by-2 into a variable-amount shifter with left, logical-right, arithmetic-right and rotate-right modes. It accepts one operand per Start/Done handshake and shifts STEP bits per clock, trading latency for area. It sits beside the ALU and executes SLL/SRL/SRA-class instructions under multi-cycle control.

## Interface
- WIDTH, 32: operand width in bits. Must be a power of two, ≥ 4.
- STEP, 1: bits shifted per SHIFT cycle. Must be a power of two, 1 ≤ STEP ≤ WIDTH.
- clk  in  1  single clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- Start  in  1  request. Accepted on a rising edge when Busy=0.
- Op  in  2  mode, sampled at accept: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- Shamt  in  $clog2(WIDTH)  shift amount, sampled at accept.
- Data_In  in  WIDTH  operand, sampled at accept.
- Busy  out  1  high while in SHIFT.
- Done  out  1  one-cycle pulse: Data_Out holds the final result.
- Data_Out  out  WIDTH  result register. Holds its value until the next accept.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- Registered state: acc (WIDTH), cnt (width of Shamt), op (2), sign (1).
- Accept happens when Start=1 in IDLE or DONE. On accept:
  - acc←Data_In, cnt←Shamt, op←Op, sign←Data_In[WIDTH-1].
  - Go to SHIFT.
- SHIFT, cnt≠0:
  - k = min(STEP, cnt).
  - acc←step(acc, op, k), cnt←cnt−k.
- SHIFT, cnt=0: go to DONE and copy acc into Data_Out.
- DONE lasts exactly one cycle, with Done=1.
  - Start=1 in DONE is accepted: go to SHIFT (back-to-back operation).
  - Otherwise go to IDLE.
- Start while Busy=1 is ignored. It is not queued, and Busy=1 only in SHIFT.
- Inputs may change freely after accept. Only the sampled copies are used.
- Step semantics for shift amount k:
  - SLL: fill with zeros from the LSB.
  - SRL: fill with zeros from the MSB.
  - SRA: fill with the sampled sign bit.
  - ROR: bits leaving at the LSB re-enter at the MSB.
- Composition of steps is exact, so the final result equals a single shift by Shamt.
- Shamt=0: result = Data_In, for every op.
- Maximum Shamt is WIDTH−1. Widths are exact, with no overflow beyond WIDTH.
- Reset at any time, including mid-operation, aborts the operation:
  - state←IDLE, Busy=0, Done=0, Data_Out=0, acc=0, cnt=0.

## Timing
- Accept at edge E0. Let n = ceil(Shamt/STEP).
- Busy=1 from E0 through E(n+1).
- Done=1 and Data_Out valid in the cycle after edge E(n+1). Latency is n+1 cycles from accept to Done.
  - Shamt=0: Done is visible 1 cycle after accept.
  - WIDTH=32, STEP=1, Shamt=31: Done is visible 32 cycles after accept.
- Throughput with back-to-back Start is one result per n+2 cycles.
- Data_Out changes only on the edge entering DONE, or on reset.
- Outputs are registered. No combinational path from inputs to outputs.

## Structure
- Package shift_unit_pkg holds:
  - The op encoding constants SHIFT_SLL=2'b00, SHIFT_SRL=2'b01, SHIFT_SRA=2'b10, SHIFT_ROR=2'b11.
  - The FSM state typedef {IDLE, SHIFT, DONE}.
- One sub-module: shift_step.
  - Combinational.
  - Parameters: WIDTH, STEP.
  - Inputs: acc, op, sign, and k (range 0..STEP).
  - Output: the shifted word.
  - This is the parametrised descendant of the fixed shift-by-2 block.
- The top level holds the FSM, the counter and the registers.

## Test plan
- Reset: assert rst mid-SHIFT (WIDTH=32, STEP=1, Shamt=20).
  - Busy, Done and Data_Out drop to 0 immediately, without a clock.
  - After release, the unit is in IDLE and accepts a new Start.
- SLL: WIDTH=32, STEP=1, Data_In=0x0000_0001, Shamt=31.
  - Done appears 32 cycles after accept.
  - Data_Out=0x8000_0000.
- SRA vs SRL: Data_In=0xF000_0000, Shamt=4.
  - SRA → 0xFF00_0000.
  - SRL → 0x0F00_0000.
  - Done 5 cycles after accept, for STEP=1.
- ROR with STEP=4: Data_In=0x1234_5678, Shamt=6.
  - Data_Out=0xE048_D159.
  - n=2, so Done 3 cycles after accept. Confirms the partial last step.
- Shamt=0: Data_In=0xDEAD_BEEF, any Op.
  - Data_Out=0xDEAD_BEEF, Done 1 cycle after accept.
- Handshake:
  - Start held high throughout operation: Start is ignored while Busy, and the operation is re-accepted in the DONE cycle.
  - Data_In changed during Busy: the result reflects the sampled operand.
  - Two back-to-back SLL-by-2 operations on 0x1 and 0x3 give 0x4 then 0xC, each with a single Done pulse.
